// File: rtl/mm_result_collector.sv
// Result collector: captures MM result words into a slot buffer, then drains the full product in index order.
// Optional build macro MM_COLLECT_TRANSPOSE_EN drains column-major (index halves swapped) instead of row-major.
module mm_result_collector #(
    parameter int DATA_W = 18,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              result_en,
    input  logic [ADDR_W-1:0] addr_P,
    input  logic [DATA_W-1:0] result,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              err
);

    typedef enum logic {COLLECT, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  mask_q;
    logic [DEPTH-1:0]  wr_onehot;
    logic [DEPTH-1:0]  mask_filled;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W-1:0] rd_idx;
    logic              err_q;
    logic              in_collect;
    logic              wr_fire;
    logic              hs;
    logic              last_hs;

    assign in_collect  = (state_q == COLLECT);
    assign wr_fire     = result_en && in_collect;
    assign wr_onehot   = {{(DEPTH-1){1'b0}}, 1'b1} << addr_P;
    // Fill detection includes the write landing this cycle
    assign mask_filled = mask_q | (wr_fire ? wr_onehot : '0);
    assign hs          = out_valid && out_ready;
    assign last_hs     = hs && out_last;
    assign err         = err_q;

`ifdef MM_COLLECT_TRANSPOSE_EN
    assign rd_idx = {rd_ptr_q[ADDR_W/2-1:0], rd_ptr_q[ADDR_W-1:ADDR_W/2]};
`else
    assign rd_idx = rd_ptr_q;
`endif

    // Storage carries no reset; the mask alone decides what is valid
    always_ff @(posedge clk) begin
        if (wr_fire)
            mem[addr_P] <= result;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= COLLECT;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        out_valid = 1'b0;
        busy      = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        case (state_q)
            COLLECT: begin
                if (&mask_filled)
                    state_d = DRAIN;
            end
            DRAIN: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_last  = (rd_ptr_q == ADDR_W'(DEPTH-1));
                out_data  = mem[rd_idx];
                if (last_hs)
                    state_d = COLLECT;
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask_q   <= '0;
            rd_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (in_collect) begin
                mask_q   <= mask_filled;
                rd_ptr_q <= '0;
            end else if (hs) begin
                rd_ptr_q <= last_hs ? '0 : rd_ptr_q + ADDR_W'(1);
                if (last_hs)
                    mask_q <= '0;
            end
            // Sticky: overwrite of a filled slot, or any write attempted while draining
            if ((result_en && !in_collect) || (wr_fire && |(mask_q & wr_onehot)))
                err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mm_result_collector.sv
// Directed bench for mm_result_collector: fill/drain, ordering, backpressure, errors, reset, back-to-back.
module tb_mm_result_collector;

    localparam int DW = 18;
    localparam int AW = 4;
    localparam int D  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          result_en = 1'b0;
    logic [AW-1:0] addr_P = '0;
    logic [DW-1:0] result = '0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_last;
    logic          busy;
    logic          err;

    int passes = 0;
    int fails  = 0;
    int total  = 0;
    int slot_val [D];
    int ord      [D];

    mm_result_collector #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .result_en(result_en), .addr_P(addr_P), .result(result),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int v);
        result_en = 1'b1;
        addr_P    = AW'(a);
        result    = DW'(v);
        slot_val[a] = v;
        tick();
    endtask

    task automatic fill(input int base, input int skip);
        for (int s = 0; s < D; s++) begin
            if (s != skip) begin
                check("pre_fill_valid", {31'b0, out_valid}, 0);
                wr(s, base + s);
            end
        end
        result_en = 1'b0;
        check("fill_valid", {31'b0, out_valid}, 1);
        check("fill_busy", {31'b0, busy}, 1);
    endtask

    // bp: ready pattern 1,0,0,1; inj/inj2: handshake index at which a dropped write is attempted
    task automatic drain(input bit bp, input int inj, input int inj2, input int stop);
        int idx = 0;
        int cyc = 0;
        bit injected;
        while (idx < stop && cyc < 100) begin
            out_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            injected  = (idx == inj) || (idx == inj2);
            result_en = injected;
            addr_P    = AW'(15);
            result    = DW'(999);
            check("drain_valid", {31'b0, out_valid}, 1);
            check("drain_busy", {31'b0, busy}, 1);
            check("drain_data", 32'(out_data), 32'(slot_val[ord[idx]]));
            check("drain_last", {31'b0, out_last}, (idx == D-1) ? 1 : 0);
            if (out_ready) idx++;
            tick();
            cyc++;
            if (injected) check("err_drop", {31'b0, err}, 1);
        end
        result_en = 1'b0;
        out_ready = 1'b1;
        check("handshakes", 32'(idx), 32'(stop));
        if (stop == D) begin
            check("post_valid", {31'b0, out_valid}, 0);
            check("post_busy", {31'b0, busy}, 0);
        end
    endtask

    initial begin
        for (int k = 0; k < D; k++) begin
`ifdef MM_COLLECT_TRANSPOSE_EN
            ord[k] = (k % 4) * 4 + (k / 4);
`else
            ord[k] = k;
`endif
        end

        // reset state
        #12;
        check("rst_valid", {31'b0, out_valid}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_last", {31'b0, out_last}, 0);
        check("rst_data", 32'(out_data), 0);
        check("rst_err", {31'b0, err}, 0);
        rst = 1'b1;
        tick();
        check("idle_valid", {31'b0, out_valid}, 0);

        // in-order fill, free-flowing drain
        fill(100, -1);
        drain(1'b0, -1, -1, D);
        check("inorder_err", {31'b0, err}, 0);

        // out-of-order fill
        for (int i = 0; i < D; i++) begin
            check("ooo_pre_valid", {31'b0, out_valid}, 0);
            wr(15 - i, 15 - i);
        end
        result_en = 1'b0;
        check("ooo_valid", {31'b0, out_valid}, 1);
        drain(1'b0, -1, -1, D);

        // backpressure
        fill(200, -1);
        drain(1'b1, -1, -1, D);
        check("bp_err", {31'b0, err}, 0);

        // duplicate write, then writes during drain (mid-drain and on the last handshake)
        wr(3, 7);
        result_en = 1'b0;
        check("dup_first_err", {31'b0, err}, 0);
        wr(3, 9);
        result_en = 1'b0;
        check("dup_err", {31'b0, err}, 1);
        fill(50, 3);
        drain(1'b0, 1, 15, D);
        check("dup_err_sticky", {31'b0, err}, 1);

        // reset mid-drain
        fill(300, -1);
        drain(1'b0, -1, -1, 5);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_valid", {31'b0, out_valid}, 0);
        check("mid_rst_busy", {31'b0, busy}, 0);
        check("mid_rst_err", {31'b0, err}, 0);
        check("mid_rst_data", 32'(out_data), 0);
        tick();
        rst = 1'b1;
        tick();
        fill(400, -1);
        drain(1'b0, -1, -1, D);

        // back-to-back: first write lands the cycle after the last handshake
        fill(500, -1);
        drain(1'b0, -1, -1, D);
        fill(600, -1);
        drain(1'b0, -1, -1, D);
        check("b2b_err", {31'b0, err}, 0);

        // drop during drain alone sets err
        fill(700, -1);
        drain(1'b1, 3, -1, D);
        check("drop_err", {31'b0, err}, 1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/mm_result_collector.md
# mm_result_collector

Consumer for the matrix-multiply result stream. It captures each result word that the MM controller/datapath emits with `result_en`/`addr_P` into an internal buffer. Once every slot of the product is filled, it drains the full buffer in index order over a valid/ready stream toward the host or output interface. It sits directly downstream of the MM controller and replaces the bare P memory.

## Interface
- `DATA_W`, default 18: width of one result word.
- `ADDR_W`, default 4: result index width. Must be even.
- `DEPTH`, default 16: number of result slots; equals 2^ADDR_W.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `result_en`  in  1  write strobe; `result` and `addr_P` are valid in this cycle.
- `addr_P`  in  ADDR_W  slot index of the incoming result.
- `result`  in  DATA_W  result word.
- `out_data`  out  DATA_W  drained word; 0 whenever `out_valid`=0.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  downstream accepts the word.
- `out_last`  out  1  current word is the final word of the drain.
- `busy`  out  1  high while in DRAIN.
- `err`  out  1  sticky error flag; cleared only by reset.

## Operation
- Internal storage: `DEPTH` x `DATA_W` register array, a `DEPTH`-bit fill mask, and an `ADDR_W`-bit `rd_ptr`. The array is not reset; the mask is.
- FSM states: COLLECT (reset state) and DRAIN.
- COLLECT:
  - On `result_en`=1, write `result` to slot `addr_P` and set `mask[addr_P]`.
  - If `mask[addr_P]` was already set, overwrite the slot and set `err`.
  - When the mask becomes all-ones, including through a write in the current cycle, go to DRAIN next cycle with `rd_ptr`=0.
- DRAIN:
  - `out_valid`=1, `busy`=1, `out_data`=mem[map(`rd_ptr`)], `out_last`=(`rd_ptr`==DEPTH-1).
  - On `out_valid`&&`out_ready`, increment `rd_ptr`.
  - On the handshake with `out_last`=1: clear the mask, set `rd_ptr`=0, return to COLLECT.
  - `result_en` during DRAIN: the word is dropped, nothing is written, and `err` is set.
- `map` is identity unless the transpose option is compiled in (see Configuration).
- `out_data`, `out_last` and `out_valid` stay stable while `out_valid`&&!`out_ready` (standard stall rule).

## Timing
- Reset values: `out_valid`=0, `out_last`=0, `out_data`=0, `busy`=0, `err`=0, mask=0, `rd_ptr`=0, state=COLLECT.
- `result_en` is sampled on the rising edge. A write is visible in the array the next cycle.
- Latency: final fill write at edge N gives `out_valid`=1 after edge N.
- Throughput: one word per cycle. With `out_ready` held high, a full drain takes exactly DEPTH cycles.
- Last handshake at edge M: `busy`=0 and `out_valid`=0 after M. A `result_en` in the cycle after M is accepted.
- A `result_en` coinciding with the last drain handshake is still in DRAIN: it is dropped and sets `err`.
- `rst` asserted mid-collect or mid-drain: all outputs take their reset values immediately (asynchronous), and partial fill is lost.
- Slots may be written in any order. Fill detection depends only on the mask, never on write count.

## Configuration
- `MM_COLLECT_TRANSPOSE_EN`:
  - Defined: drain order is column-major. `map(i)` = {i[ADDR_W/2-1:0], i[ADDR_W-1:ADDR_W/2]}, i.e. index halves are swapped. For DEPTH=16, `rd_ptr` 1 reads slot 4, and `rd_ptr` 4 reads slot 1.
  - Undefined: `map(i)`=i, so the drain is row-major. No transpose logic is present.
  - `out_last` always tracks `rd_ptr`, not the mapped index.

## Test plan
- Reset then in-order fill: write slots 0..15 with `result`=100+i, `out_ready`=1 -> `out_valid` rises the cycle after the 16th write; `out_data` 100..115 over 16 consecutive cycles; `out_last` only on 115; `busy` then drops; `err`=0.
- Out-of-order fill: write slots 15 down to 0 with values 15-i -> drain starts only after slot 0 is written; the row-major drain gives 0..15 in slot order. With `MM_COLLECT_TRANSPOSE_EN` defined, the drain outputs values in slot order 0,4,8,12,1,5,...
- Backpressure: toggle `out_ready` 1,0,0,1 repeatedly during the drain -> no word is lost or duplicated; `out_data` holds while stalled; the drain completes after exactly 16 handshakes.
- Duplicate write: write slot 3 twice (values 7 then 9) during COLLECT -> `err`=1 the next cycle, and slot 3 drains as 9. A `result_en` during DRAIN is dropped and `err` stays 1.
- Reset mid-drain: pull `rst` low after 5 handshakes -> `out_valid`, `busy` and `err` go to 0 immediately. A fresh 16-word fill then drains correctly starting from slot 0.
- Back-to-back: a `result_en` in the cycle right after the last handshake is captured, and a second full fill/drain completes correctly.
